// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: nibble-serial instruction fetch sequencer feeding the IR
module instr_fetch_seq #(
  parameter int ADDR_W = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [3:0]        ir_en,
  output logic              busy,
  output logic              fetch_done,
  output logic [ADDR_W-1:0] pc
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_fa, w_start;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_nib;
  logic [3:0]        r_ir_en;
  logic              w_accept, w_start_fetch;
  // next state, read strobe and status decode
  always_comb begin
    w_start       = pc_load ? pc_next : r_pc;
    w_start_fetch = r_state == S_IDLE && fetch_req;
    w_accept      = r_state == S_ISSUE && mem_ready;
    w_state_nxt   = w_start_fetch                 ? S_ISSUE :
                    (w_accept && r_nib == 2'd3)   ? S_DRAIN :
                    r_state == S_DRAIN            ? S_DONE  :
                    r_state == S_DONE             ? S_IDLE  : r_state;
    mem_rd        = r_state == S_ISSUE;
    busy          = r_state != S_IDLE;
    fetch_done    = r_state == S_DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end
  // PC, fetch address, nibble counter, address and IR-enable pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_fa    <= '0;
      r_nib   <= '0;
      r_addr  <= '0;
      r_ir_en <= '0;
    end else begin
      r_ir_en <= w_accept ? 4'b1000 >> r_nib : 4'b0000;
      if (w_start_fetch) begin
        r_fa   <= w_start;
        r_nib  <= '0;
        r_addr <= {w_start, 2'b00};
      end
      if (w_accept) begin
        r_nib <= r_nib + 2'd1;
        if (r_nib != 2'd3) r_addr <= {r_fa, r_nib + 2'd1};
      end
      if (r_state == S_IDLE && pc_load) r_pc <= pc_next;
      if (r_state == S_DONE) r_pc <= pc_load ? pc_next : r_fa + ADDR_W'(1);
    end
  end
  assign mem_addr = r_addr;
  assign ir_en    = r_ir_en;
  assign pc       = r_pc;
endmodule
